fcvt_pipe: RTL

FCVT_PIPE -- requirements
Module: fcvt_pipe

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fcvt_rne.sv | 25 ++
 rtl/fcvt_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP conversion pipe: op codes, flag positions,
// integer saturation limits, exponent bias and the stage-1 payload.
package fpu_pkg;

  typedef enum logic {
    OP_FTOI = 1'b0,
    OP_ITOF = 1'b1
  } op_e;

  // Stage-1 classification of an operand.
  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_SAT  = 2'd2
  } kind_e;

  localparam int unsigned FLAG_INEXACT = 0;
  localparam int unsigned FLAG_INVALID = 1;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [7:0]  FP_BIAS = 8'd127;

  // Aligned operand handed from S1 to S2.
  // FTOI: mag is the integer part (exact when guard/sticky are 0).
  // ITOF: mag[23:0] is the normalised 24-bit mantissa, expo the biased exponent.
  typedef struct packed {
    op_e         op;
    kind_e       kind;
    logic        sign;
    logic [7:0]  expo;
    logic [31:0] mag;
    logic        guard;
    logic        sticky;
  } s1_t;

endpackage

// File: rtl/fcvt_rne.sv
// Round-to-nearest-even of a W-bit mantissa given its guard and sticky bits.
module fcvt_rne #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] mant_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  output logic [W-1:0] rounded_o,
  output logic         carry_o,
  output logic         inexact_o
);

  logic         round_up;
  logic [W:0]   sum;

  // Increment on more-than-half, or exactly half with an odd LSB.
  always_comb begin
    round_up  = guard_i & (sticky_i | mant_i[0]);
    sum       = {1'b0, mant_i} + {{W{1'b0}}, round_up};
    rounded_o = sum[W-1:0];
    carry_o   = sum[W];
    inexact_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/fcvt_pipe.sv
// Two-stage float<->int converter with valid/ready handshake on both sides.
// S1 unpacks and aligns the operand; S2 rounds, saturates and packs.
module fcvt_pipe #(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_flags
);
  import fpu_pkg::*;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d, s1_new;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [1:0]       out_flags_q, out_flags_d;

  logic             s2_load, accept;
  logic [7:0]       f_exp, r_dist;
  logic [23:0]      f_man;
  logic [5:0]       f_rsh;
  logic [47:0]      f_ext;
  logic [31:0]      i_mag, i_norm;
  logic [4:0]       i_msb;
  logic [23:0]      rne_rounded;
  logic             rne_carry, rne_inexact;
  logic [31:0]      f_int, res_data;
  logic [1:0]       res_flags;

  // Handshake: S2 loads when empty or drained; S1 follows S2.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    accept   = in_valid && in_ready;
  end

  // S1 datapath: classify and align the incoming operand.
  always_comb begin
    f_exp  = in_data[30:23];
    f_man  = {1'b1, in_data[22:0]};
    r_dist = 8'd150 - f_exp;
    // Any right shift past 47 leaves only sticky, same as 47.
    f_rsh  = (r_dist > 8'd47) ? 6'd47 : r_dist[5:0];
    f_ext  = {f_man, 24'b0} >> f_rsh;
    i_mag  = in_data[31] ? (~in_data + 32'd1) : in_data;
    i_msb  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i_mag[i]) i_msb = 5'(i);
    end
    i_norm = i_mag << (5'd31 - i_msb);

    s1_new      = '0;
    s1_new.op   = op_e'(in_op);
    s1_new.sign = in_data[31];
    s1_new.kind = K_NORM;
    if (op_e'(in_op) == OP_FTOI) begin
      if (f_exp == '0) begin
        s1_new.kind = K_ZERO;
      end else if (f_exp == '1 && in_data[22:0] != '0) begin
        s1_new.kind = K_SAT;
        s1_new.sign = 1'b0;
      end else if (f_exp >= 8'd158) begin
        if (in_data == 32'hCF00_0000) s1_new.mag = INT_MIN;
        else                          s1_new.kind = K_SAT;
      end else if (f_exp >= 8'd150) begin
        s1_new.mag = {8'b0, f_man} << (f_exp - 8'd150);
      end else begin
        s1_new.mag    = {8'b0, f_ext[47:24]};
        s1_new.guard  = f_ext[23];
        s1_new.sticky = |f_ext[22:0];
      end
    end else begin
      if (i_mag == '0) begin
        s1_new.kind = K_ZERO;
        s1_new.sign = 1'b0;
      end else begin
        s1_new.expo   = FP_BIAS + {3'b0, i_msb};
        s1_new.mag    = {8'b0, i_norm[31:8]};
        s1_new.guard  = i_norm[7];
        s1_new.sticky = |i_norm[6:0];
      end
    end
  end

  // S1 register next state.
  always_comb begin
    s1_d     = s1_q;
    s1_tag_d = s1_tag_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    else              s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_d     = s1_new;
      s1_tag_d = in_tag;
    end
  end

  fcvt_rne #(.W(24)) u_rne (
    .mant_i    (s1_q.mag[23:0]),
    .guard_i   (s1_q.guard),
    .sticky_i  (s1_q.sticky),
    .rounded_o (rne_rounded),
    .carry_o   (rne_carry),
    .inexact_o (rne_inexact)
  );

  // S2 datapath: round, saturate, apply sign and pack.
  always_comb begin
    // Exact wide FTOI values never round, so the carry cannot collide with mag[24].
    f_int     = {s1_q.mag[31:25], s1_q.mag[24] | rne_carry, rne_rounded};
    res_data  = '0;
    res_flags = '0;
    if (s1_q.kind != K_ZERO) begin
      if (s1_q.op == OP_FTOI) begin
        if (s1_q.kind == K_SAT) begin
          res_data               = s1_q.sign ? INT_MIN : INT_MAX;
          res_flags[FLAG_INVALID] = 1'b1;
        end else begin
          res_data               = s1_q.sign ? (~f_int + 32'd1) : f_int;
          res_flags[FLAG_INEXACT] = rne_inexact;
        end
      end else begin
        res_data               = {s1_q.sign, s1_q.expo + {7'b0, rne_carry}, rne_rounded[22:0]};
        res_flags[FLAG_INEXACT] = rne_inexact;
      end
    end
  end

  // S2 register next state; outputs hold while stalled.
  always_comb begin
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_flags_d = out_flags_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d  = res_data;
        out_tag_d   = s1_tag_q;
        out_flags_d = res_flags;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_flags = out_flags_q;

endmodule
